// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the MEM/WB payload field layout and the skid-slot state encoding.
package pipe_pkg;

    // MEM/WB payload layout: {alu_res[31:0], mem_data[31:0], rd[4:0], mem2reg, regwr}
    localparam int unsigned MEMWB_W     = 71;
    localparam int unsigned RES_LSB     = 39;
    localparam int unsigned MDATA_LSB   = 7;
    localparam int unsigned RD_LSB      = 2;
    localparam int unsigned MEM2REG_BIT = 1;
    localparam int unsigned REGWR_BIT   = 0;

    // Bit 0 mirrors the main-register valid, bit 1 the skid-register valid.
    typedef enum logic [1:0] {
        SlotEmpty = 2'b00,
        SlotOne   = 2'b01,
        SlotTwo   = 2'b11
    } slot_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a main register plus a skid register so the slot can
// keep accepting for one cycle after downstream stalls, giving full throughput
// without a combinational out_ready -> in_ready path.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   flush             synchronous kill of both entries (data kept, valids cleared)
//   in_valid/in_ready/in_data     upstream handshake (in_ready straight from flop)
//   out_valid/out_ready/out_data  downstream handshake (out_data = main register)
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              accept, emit;
    logic              load_main_in, load_main_skid, load_skid;

    // Gated by rst so nothing upstream sees a ready slot during reset.
    assign in_ready  = rst & ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Same-cycle accept is dropped; data registers deliberately hold.
            state_d = SlotEmpty;
        end else begin
            unique case (state_q)
                SlotEmpty: begin
                    if (accept) begin
                        state_d      = SlotOne;
                        load_main_in = 1'b1;
                    end
                end
                SlotOne: begin
                    if (accept && !emit) begin
                        state_d   = SlotTwo;
                        load_skid = 1'b1;
                    end else if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (emit) begin
                        state_d = SlotEmpty;
                    end
                end
                SlotTwo: begin
                    if (emit) begin
                        state_d        = SlotOne;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = SlotEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SlotEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register: STAGES chained skid slots carrying an
// opaque DATA_W payload, plus a saturating stall counter for perf debug.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   flush             synchronous kill of every in-flight entry
//   in_valid/in_ready/in_data     upstream side (slot 0)
//   out_valid/out_ready/out_data  downstream side (slot STAGES-1)
//   stall_cnt         cycles with out_valid & ~out_ready, saturating
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = MEMWB_W,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    // Element k is the link feeding slot k; element STAGES is the stage output.
    logic              link_valid [STAGES+1];
    logic              link_ready [STAGES+1];
    logic [DATA_W-1:0] link_data  [STAGES+1];
    logic [CNT_W-1:0]  stall_q;

    assign link_valid[0]      = in_valid;
    assign link_data[0]       = in_data;
    assign in_ready           = link_ready[0];
    assign out_valid          = link_valid[STAGES];
    assign out_data           = link_data[STAGES];
    assign link_ready[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        pipe_skid_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (link_valid[g]),
            .in_ready  (link_ready[g]),
            .in_data   (link_data[g]),
            .out_valid (link_valid[g+1]),
            .out_ready (link_ready[g+1]),
            .out_data  (link_data[g+1])
        );
    end

    // A flushed head is neither emitted nor stalled, so flush blocks counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != CntMax)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

    localparam int unsigned W = 71;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    // Index 0: STAGES=1, CNT_W=4. Index 1: STAGES=2, CNT_W=16.
    logic         dr [2];
    logic         dv [2];
    logic [W-1:0] dd [2];
    logic [3:0]   sc_a;
    logic [15:0]  sc_b;
    logic [15:0]  sc [2];

    always_comb begin
        sc[0] = {12'd0, sc_a};
        sc[1] = sc_b;
    end

    pipe_skid_stage #(.DATA_W(W), .STAGES(1), .CNT_W(4)) u_s1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(dr[0]), .in_data(in_data),
        .out_valid(dv[0]), .out_ready(out_ready), .out_data(dd[0]),
        .stall_cnt(sc_a)
    );

    pipe_skid_stage #(.DATA_W(W), .STAGES(2), .CNT_W(16)) u_s2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(dr[1]), .in_data(in_data),
        .out_valid(dv[1]), .out_ready(out_ready), .out_data(dd[1]),
        .stall_cnt(sc_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each slot is a FIFO of at most two entries.
    logic [W-1:0] mq [8][$];
    int unsigned  ms [2];

    function automatic int stages_of(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int unsigned max_of(int i);
        return (i == 0) ? 15 : 65535;
    endfunction

    function automatic int head_idx(int i);
        return i * 4 + stages_of(i) - 1;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            int s;
            bit rdy [5];
            bit vld [5];
            s = stages_of(i);
            if (!rst || flush) begin
                for (int k = 0; k < 4; k++) mq[i*4+k].delete();
                if (!rst) ms[i] = 0;
            end else begin
                for (int k = 0; k < 5; k++) begin
                    rdy[k] = (k < s) ? (mq[i*4+k].size() < 2) : 1'b0;
                    vld[k] = (k < s) ? (mq[i*4+k].size() > 0) : 1'b0;
                end
                if (vld[s-1] && !out_ready && ms[i] < max_of(i)) ms[i]++;
                for (int k = s - 1; k >= 0; k--) begin
                    bit go;
                    logic [W-1:0] e;
                    go = (k == s - 1) ? out_ready : rdy[k+1];
                    if (vld[k] && go) begin
                        e = mq[i*4+k].pop_front();
                        if (k < s - 1) mq[i*4+k+1].push_back(e);
                    end
                end
                if (in_valid && rdy[0]) mq[i*4].push_back(in_data);
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 71'h1; out_ready = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (dr[i] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 0", i, dr[i]); end
            checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", i, dv[i]); end
            checks++; if (dd[i] !== '0) begin errors++; $display("FAIL reset_out_data[%0d] got %h want 0", i, dd[i]); end
            checks++; if (sc[i] !== 16'd0) begin errors++; $display("FAIL reset_stall[%0d] got %0d want 0", i, sc[i]); end
        end
        rst = 1'b1; in_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (dr[i] !== 1'b1) begin errors++; $display("FAIL release_in_ready[%0d] got %b want 1", i, dr[i]); end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            in_valid = (j < 8);
            in_data  = 71'(16 + j);
            tick();
            checks++;
            if (dv[1] !== (j >= 1 && j <= 8)) begin
                errors++; $display("FAIL stream_valid cyc%0d got %b want %b", j, dv[1], (j >= 1 && j <= 8));
            end
            if (j >= 1 && j <= 8) begin
                checks++;
                if (dd[1] !== 71'(16 + j - 1)) begin
                    errors++; $display("FAIL stream_data cyc%0d got %h want %h", j, dd[1], 71'(16 + j - 1));
                end
            end
            checks++; if (dr[1] !== 1'b1) begin errors++; $display("FAIL stream_ready cyc%0d got %b want 1", j, dr[1]); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got [$];
        logic [W-1:0] exp_v [3];
        int unsigned  base;
        bit           acc;
        exp_v[0] = 71'hA; exp_v[1] = 71'hB; exp_v[2] = 71'hC;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 71'hA;
        checks++; if (dr[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_a got %b want 1", dr[0]); end
        tick();
        in_data = 71'hB;
        checks++; if (dr[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_b got %b want 1", dr[0]); end
        tick();
        in_data = 71'hC;
        base = ms[0];
        for (int n = 1; n <= 3; n++) begin
            checks++; if (dr[0] !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", dr[0]); end
            tick();
            checks++; if (dv[0] !== 1'b1 || dd[0] !== 71'hA) begin
                errors++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=a", dv[0], dd[0]);
            end
            checks++; if (sc[0] !== 16'(base + n)) begin
                errors++; $display("FAIL bp_stall got %0d want %0d", sc[0], base + n);
            end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (dv[0]) got.push_back(dd[0]);
            acc = in_valid && dr[0];
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got.size()); end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checks++; if (got[k] !== exp_v[k]) begin
                errors++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], exp_v[k]);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        logic [W-1:0] got [$];
        out_ready = 1'b0; in_valid = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            in_data = 71'(j);
            tick();
        end
        checks++; if (dv[1] !== 1'b1 || dd[1] !== 71'h1) begin
            errors++; $display("FAIL flush_prefill got v=%b d=%h want v=1 d=1", dv[1], dd[1]);
        end
        flush = 1'b1; in_data = 71'h55; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (dv[i] !== 1'b0) begin errors++; $display("FAIL flush_valid[%0d] got %b want 0", i, dv[i]); end
            checks++; if (dr[i] !== 1'b1) begin errors++; $display("FAIL flush_ready[%0d] got %b want 1", i, dr[i]); end
        end
        in_valid = 1'b1; in_data = 71'h66;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (dv[1]) got.push_back(dd[1]);
            tick();
        end
        checks++; if (got.size() != 1) begin errors++; $display("FAIL flush_after_count got %0d want 1", got.size()); end
        if (got.size() > 0) begin
            checks++; if (got[0] !== 71'h66) begin errors++; $display("FAIL flush_after_data got %h want 66", got[0]); end
        end
        drain();
    endtask

    task automatic test_saturation();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 71'h77;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (sc[0] !== 16'd15 || dv[0] !== 1'b1) begin
            errors++; $display("FAIL sat_stop got cnt=%0d v=%b want cnt=15 v=1", sc[0], dv[0]);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (sc[0] !== 16'd15 || dv[0] !== 1'b0) begin
            errors++; $display("FAIL sat_flush got cnt=%0d v=%b want cnt=15 v=0", sc[0], dv[0]);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if (sc[0] !== 16'd0 || sc[1] !== 16'd0) begin
            errors++; $display("FAIL sat_reset got %0d/%0d want 0/0", sc[0], sc[1]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 71'h21; tick();
        in_data = 71'h22; tick();
        in_valid = 1'b0;
        checks++; if (dv[0] !== 1'b1 || dv[1] !== 1'b1) begin
            errors++; $display("FAIL mid_prefill got %b/%b want 1/1", dv[0], dv[1]);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++; if (dv[i] !== 1'b0 || dd[i] !== '0 || sc[i] !== 16'd0 || dr[i] !== 1'b0) begin
                errors++; $display("FAIL mid_reset[%0d] got v=%b d=%h c=%0d r=%b want 0/0/0/0",
                                   i, dv[i], dd[i], sc[i], dr[i]);
            end
        end
        rst = 1'b1; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++; if (dv[0] !== 1'b0 || dv[1] !== 1'b0) begin
                errors++; $display("FAIL mid_stale cyc%0d got %b/%b want 0/0", n, dv[0], dv[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [95:0] r;
        for (int n = 0; n < 400; n++) begin
            r = {$urandom(), $urandom(), $urandom()};
            in_data   = r[W-1:0];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) != 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                int h;
                bit mv;
                h  = head_idx(i);
                mv = (mq[h].size() > 0);
                checks++; if (dr[i] !== (rst && mq[i*4].size() < 2)) begin
                    errors++; $display("FAIL rnd_ready[%0d] cyc%0d got %b want %b", i, n, dr[i], (rst && mq[i*4].size() < 2));
                end
                checks++; if (dv[i] !== mv) begin
                    errors++; $display("FAIL rnd_valid[%0d] cyc%0d got %b want %b", i, n, dv[i], mv);
                end
                if (mv) begin
                    checks++; if (dd[i] !== mq[h][0]) begin
                        errors++; $display("FAIL rnd_data[%0d] cyc%0d got %h want %h", i, n, dd[i], mq[h][0]);
                    end
                end
                checks++; if (sc[i] !== 16'(ms[i])) begin
                    errors++; $display("FAIL rnd_stall[%0d] cyc%0d got %0d want %0d", i, n, sc[i], ms[i]);
                end
            end
        end
        rst = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
